ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//  Upstream controller for the 32x4 single-port switch-driven RAM stage.
//  Turns raw switch/key inputs into clean RAM address/data/write-enable.
//  Modes: manual single write, timed auto-scan of all addresses, bulk fill.
//  Outputs feed the RAM address/data/wren pins and the address hex display.
// PARAMETERS
//  ADDR_W       5           RAM address width (depth 2**ADDR_W)
//  DATA_W       4           RAM data width
//  SCAN_DIV     50_000_000  clocks per auto-scan step (1 s at 50 MHz)
// PORTS
//  CLOCK_50   in   1       system clock, all logic on rising edge
//  reset      in   1       asynchronous, active-high reset
//  mode       in   2       00 manual, 01 auto-scan, 10 fill, 11 = manual
//  wr_req     in   1       raw async write/start key (level, active-high)
//  addr_sw    in   ADDR_W  manual address
//  data_sw    in   DATA_W  write data (manual and fill)
//  ram_addr   out  ADDR_W  registered RAM address
//  ram_data   out  DATA_W  registered RAM write data
//  ram_wren   out  1       registered RAM write enable
//  busy       out  1       high while FILL in progress
//  state_o    out  2       current FSM state (LED debug)
// BEHAVIOUR
//  Reset: ram_addr=0, ram_data=0, ram_wren=0, busy=0, state=IDLE,
//   prescaler=0, sync FFs and edge-prev reg = 1 (key held through reset
//   never produces a pulse; must be seen low first).
//  wr_req: 2-FF synchronizer -> edge detect; wr_pulse = sync2 & ~prev.
//   Rising wr_req first sampled at edge N -> ram_wren high after edge N+2,
//   for exactly one cycle (manual). Release/re-press needed per pulse.
//  States: IDLE(00), SCAN(01), FILL(10); 11 unused -> IDLE.
//  IDLE: ram_addr<=addr_sw every cycle; ram_data<=data_sw every cycle.
//   wr_pulse & mode!=01,10 -> ram_wren=1 one cycle at current addr/data.
//   wr_pulse & mode==10 -> FILL, ram_addr<=0, busy<=1.
//   mode==01 -> SCAN, prescaler<=0, ram_addr holds current value.
//  SCAN: ram_wren=0; prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1
//   prescaler<=0 and ram_addr<=ram_addr+1 mod 2**ADDR_W (31->0).
//   wr_pulse ignored. mode!=01 -> IDLE next cycle, prescaler<=0.
//  FILL: ram_wren=1, ram_data=data_sw latched at entry (constant during
//   fill), ram_addr 0..31 one per cycle, 32 write cycles total. After
//   addr 31 written: ram_wren=0, busy=0, IDLE. mode and wr_pulse ignored
//   until done; wr_pulse arriving during FILL is discarded, not queued.
//  Reset mid-FILL/SCAN aborts immediately to reset values; no resume.
//  Simultaneous mode change and wr_pulse in IDLE: mode decides
//   (01 -> SCAN wins, pulse dropped; 10 -> FILL).
//  All outputs registered; no combinational input-to-output paths.
// STRUCTURE
//  Package ram_ctrl_pkg: state encodings ST_IDLE/ST_SCAN/ST_FILL,
//   mode encodings MODE_MAN/MODE_SCAN/MODE_FILL, default widths.
//  Sub-module sync_edge_det: 2-FF synchronizer + rising-edge pulse,
//   reset value 1, parameter-free, one instance for wr_req.
//  Top: FSM, prescaler counter, address counter, output registers.
// TESTING (bench overrides SCAN_DIV=4)
//  Manual: mode=00, addr_sw=5'h0A, data_sw=4'h7, wr_req 0->1 held 10 clk
//   -> ram_wren high exactly 1 cycle, 3rd edge after wr_req seen high,
//   ram_addr=0A, ram_data=7.
//  Reset guard: wr_req=1 during and after reset release -> no ram_wren
//   until wr_req 1->0->1.
//  Scan wrap: ram_addr=30, mode=01 -> addr 31 after 4 clk, 0 after 8 clk,
//   ram_wren stays 0; wr_req pulses ignored.
//  Fill: mode=10, data_sw=4'hC, pulse -> busy=1, 32 consecutive wren
//   cycles addr 0..31 data C; data_sw changed mid-fill to 3 has no effect;
//   busy=0 and IDLE after addr 31.
//  Mid-fill reset: reset at addr 12 -> all outputs 0 same cycle
//   (async), state IDLE, no further writes after release.
//  Mid-fill mode change to 01 -> fill completes all 32, then SCAN.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared encodings and default widths for the switch-driven RAM access controller.
//   state_t  : controller FSM states (IDLE/SCAN/FILL), also shown on debug LEDs
//   MODE_*   : decoding of the 2-bit mode switches
package ram_ctrl_pkg;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 4;
  localparam int SCAN_DIV_DEF = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_FILL = 2'b10
  } state_t;

  // 2'b11 is treated as manual.
  localparam logic [1:0] MODE_MAN  = 2'b00;
  localparam logic [1:0] MODE_SCAN = 2'b01;
  localparam logic [1:0] MODE_FILL = 2'b10;
endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk      in  sampling clock
//   rst      in  async active-high reset
//   i_async  in  raw asynchronous level input
//   o_pulse  out one-cycle pulse on a synchronized 0->1 transition
// All flops reset to 1, so an input held high through reset must first be
// seen low before it can produce a pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);
  logic r_sync1, r_sync2, r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;
endmodule

// File: rtl/ram_access_ctrl.sv
// Upstream controller for the single-port switch-driven RAM stage.
// Turns switch/key inputs into registered RAM address/data/write-enable.
//   CLOCK_50  in   system clock
//   reset     in   async active-high reset
//   mode      in   00/11 manual, 01 auto-scan, 10 bulk fill
//   wr_req    in   raw write/start key
//   addr_sw   in   manual address
//   data_sw   in   write data (manual and fill)
//   ram_addr  out  registered RAM address
//   ram_data  out  registered RAM write data
//   ram_wren  out  registered RAM write enable
//   busy      out  high while a fill is running
//   state_o   out  current FSM state
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr_sw,
  input  logic [DATA_W-1:0] data_sw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic [1:0]        state_o
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [DATA_W-1:0] r_data, w_data_nx;
  logic              r_wren, w_wren_nx;
  logic              r_busy, w_busy_nx;
  logic [PW-1:0]     r_presc, w_presc_nx;
  logic              w_pulse;

  sync_edge_det u_wr_sync (
    .clk     (CLOCK_50),
    .rst     (reset),
    .i_async (wr_req),
    .o_pulse (w_pulse)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_wren  <= 1'b0;
      r_busy  <= 1'b0;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
      r_wren  <= w_wren_nx;
      r_busy  <= w_busy_nx;
      r_presc <= w_presc_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    w_wren_nx  = 1'b0;
    w_busy_nx  = r_busy;
    w_presc_nx = r_presc;
    case (r_state)
      ST_IDLE: begin
        w_addr_nx  = addr_sw;
        w_data_nx  = data_sw;
        w_presc_nx = '0;
        // Mode selection outranks a coincident key pulse; scan starts
        // from whatever address is currently presented.
        if (mode == MODE_SCAN) begin
          w_state_nx = ST_SCAN;
          w_addr_nx  = r_addr;
        end else if (w_pulse) begin
          w_wren_nx = 1'b1;
          if (mode == MODE_FILL) begin
            // data_sw captured here stays constant for the whole fill
            w_state_nx = ST_FILL;
            w_addr_nx  = '0;
            w_busy_nx  = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (mode != MODE_SCAN) begin
          w_state_nx = ST_IDLE;
          w_presc_nx = '0;
        end else if (r_presc == PRESC_LAST) begin
          w_presc_nx = '0;
          w_addr_nx  = r_addr + ADDR_W'(1);
        end else begin
          w_presc_nx = r_presc + PW'(1);
        end
      end
      ST_FILL: begin
        if (r_addr == {ADDR_W{1'b1}}) begin
          w_state_nx = ST_IDLE;
          w_busy_nx  = 1'b0;
        end else begin
          w_addr_nx = r_addr + ADDR_W'(1);
          w_wren_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_busy_nx  = 1'b0;
        w_presc_nx = '0;
      end
    endcase
  end

  assign ram_addr = r_addr;
  assign ram_data = r_data;
  assign ram_wren = r_wren;
  assign busy     = r_busy;
  assign state_o  = r_state;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: every expected RAM write is queued
// when stimulus is issued; a negedge monitor pops one entry per ram_wren cycle.
module tb_ram_access_ctrl;
  localparam int AW = 5;
  localparam int DW = 4;
  localparam int DIV = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic          wr_req;
  logic [AW-1:0] addr_sw;
  logic [DW-1:0] data_sw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic          busy;
  logic [1:0]    state_o;

  int  total = 0;
  int  bad = 0;
  wr_t expq[$];

  ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SCAN_DIV(DIV)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .mode     (mode),
    .wr_req   (wr_req),
    .addr_sw  (addr_sw),
    .data_sw  (data_sw),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .busy     (busy),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // monitor: each write cycle must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ram_wren) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d want no write", ram_addr, ram_data);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("write_addr", int'(ram_addr), int'(e.addr));
        chk("write_data", int'(ram_data), int'(e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // manual write: a clean 0->1 edge produces exactly one write
  task automatic man_write(input logic [1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    mode = m; addr_sw = a; data_sw = d; wr_req = 1'b0;
    tick(3);
    e.addr = a; e.data = d;
    expq.push_back(e);
    wr_req = 1'b1;
    tick(10);
    wr_req = 1'b0;
    tick(3);
  endtask

  task automatic push_fill(input logic [DW-1:0] d);
    wr_t e;
    for (int i = 0; i < 32; i++) begin
      e.addr = AW'(i); e.data = d;
      expq.push_back(e);
    end
  endtask

  // full fill; data_sw changed and key re-pressed mid-fill must not matter
  task automatic fill(input logic [DW-1:0] d, input logic [DW-1:0] d_mid);
    mode = 2'b10; data_sw = d; wr_req = 1'b0;
    tick(3);
    push_fill(d);
    wr_req = 1'b1;
    tick(4);
    chk("fill_busy_hi", int'(busy), 1);
    chk("fill_state", int'(state_o), 2);
    data_sw = d_mid;
    wr_req = 1'b0;
    tick(3);
    wr_req = 1'b1;
    tick(40);
    chk("fill_busy_lo", int'(busy), 0);
    chk("fill_done_idle", int'(state_o), 0);
    chk("fill_all_written", expq.size(), 0);
    wr_req = 1'b0;
    mode = 2'b00;
    tick(3);
  endtask

  // scan from start for k steps, checking address just before and at each step boundary
  task automatic scan(input logic [AW-1:0] start, input int k);
    mode = 2'b00; addr_sw = start; wr_req = 1'b0;
    tick(3);
    mode = 2'b01;
    wr_req = 1'b1;                 // key edge lands inside SCAN and must be ignored
    repeat (DIV * k) @(posedge clk);
    @(negedge clk);
    chk("scan_pre_step", int'(ram_addr), (int'(start) + k - 1) % 32);
    chk("scan_state", int'(state_o), 1);
    @(posedge clk);
    @(negedge clk);
    chk("scan_step", int'(ram_addr), (int'(start) + k) % 32);
    #4;
    mode = 2'b00; wr_req = 1'b0;
    tick(2);
    chk("scan_exit_idle", int'(state_o), 0);
  endtask

  initial begin
    bit found;
    reset = 1'b1; mode = 2'b00; wr_req = 1'b1; addr_sw = '0; data_sw = '0;
    #23;
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_data", int'(ram_data), 0);
    chk("rst_wren", int'(ram_wren), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_state", int'(state_o), 0);

    // key held high through reset release: no write may occur
    addr_sw = 5'h03; data_sw = 4'h1;
    tick(1);
    reset = 1'b0;
    tick(10);
    wr_req = 1'b0;
    tick(3);

    // directed manual write with latency check
    addr_sw = 5'h0A; data_sw = 4'h7;
    tick(2);
    expq.push_back('{addr: 5'h0A, data: 4'h7});
    wr_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("man_lat_early", int'(ram_wren), 0);
    @(posedge clk);
    @(negedge clk);
    chk("man_lat_edge3", int'(ram_wren), 1);
    chk("man_addr", int'(ram_addr), 'h0A);
    chk("man_data", int'(ram_data), 7);
    tick(8);
    wr_req = 1'b0;
    tick(3);
    chk("man_one_write", expq.size(), 0);

    scan(5'd30, 1);
    scan(5'd30, 2);
    fill(4'hC, 4'h3);

    // mid-fill mode change to scan: fill still completes, then SCAN
    mode = 2'b10; data_sw = 4'h5; wr_req = 1'b0;
    tick(3);
    push_fill(4'h5);
    wr_req = 1'b1;
    tick(10);
    mode = 2'b01;
    tick(40);
    chk("fill_then_scan", int'(state_o), 1);
    chk("fill_then_scan_n", expq.size(), 0);
    mode = 2'b00; wr_req = 1'b0;
    tick(3);

    // mid-fill reset at address 12
    mode = 2'b10; data_sw = 4'h9; wr_req = 1'b0;
    tick(3);
    push_fill(4'h9);
    wr_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (ram_wren && ram_addr == 5'd12) found = 1'b1;
    end
    chk("midfill_reach12", int'(found), 1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_addr", int'(ram_addr), 0);
    chk("midrst_wren", int'(ram_wren), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_state", int'(state_o), 0);
    expq.delete();
    mode = 2'b00;
    tick(2);
    reset = 1'b0;
    tick(40);
    wr_req = 1'b0;
    tick(3);

    // randomized mix
    for (int n = 0; n < 12; n++) begin
      int sel;
      sel = $urandom_range(0, 3);
      if (sel <= 1)
        man_write($urandom_range(0, 1) ? 2'b11 : 2'b00, AW'($urandom), DW'($urandom));
      else if (sel == 2)
        scan(AW'($urandom), $urandom_range(1, 5));
      else
        fill(DW'($urandom), DW'($urandom));
    end

    tick(5);
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
